// File: rtl/smol_pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : smol_pc_pkg
//  Purpose  : Shared types and constants for the next-PC unit.
//  Revision : 1.0 - initial release
// ============================================================================
package smol_pc_pkg;

    typedef enum logic [2:0] {
        RK_BR   = 3'd0,
        RK_JAL  = 3'd1,
        RK_JALR = 3'd2,
        RK_TRAP = 3'd3,
        RK_XRET = 3'd4
    } redirect_kind_t;

    localparam logic [2:0] STEP_32 = 3'd4;
    localparam logic [2:0] STEP_16 = 3'd2;

endpackage : smol_pc_pkg
`default_nettype wire

// File: rtl/smol_pc_target.sv
`default_nettype none
// ============================================================================
//  Module   : smol_pc_target
//  Purpose  : Combinational redirect target, take and misalignment decode.
//  Revision : 1.0 - initial release
// ============================================================================
module smol_pc_target
    import smol_pc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit C_EXT = 1'b0
) (
    input  logic                i_redirect_valid,
    input  redirect_kind_t      i_redirect_kind,
    input  logic                i_br_taken,
    input  logic [XLEN-1:0]     i_redirect_pc,
    input  logic [XLEN-1:0]     i_rs1,
    input  logic [XLEN-1:0]     i_imm,
    input  logic [XLEN-1:0]     i_trap_vector,
    input  logic [XLEN-1:0]     i_epc,
    output logic [XLEN-1:0]     o_target,
    output logic                o_take,
    output logic                o_misalign
);

    localparam logic [XLEN-1:0] c_CLR_B0   = ~XLEN'(1);
    localparam logic [XLEN-1:0] c_CLR_B10  = ~XLEN'(3);
    localparam logic [XLEN-1:0] c_XRET_MSK = C_EXT ? c_CLR_B0 : c_CLR_B10;

    logic [XLEN-1:0] w_rel_target;
    logic [XLEN-1:0] w_jalr_target;
    logic [XLEN-1:0] w_target;
    logic            w_is_ctrl;
    logic            w_is_sys;
    logic            w_misalign;

    assign w_rel_target  = i_redirect_pc + i_imm;
    assign w_jalr_target = (i_rs1 + i_imm) & c_CLR_B0;

    // w_is_ctrl marks a transfer that is subject to the alignment check;
    // a not-taken branch never raises it and so is ignored outright.
    always_comb begin
        w_target  = '0;
        w_is_ctrl = 1'b0;
        w_is_sys  = 1'b0;
        case (i_redirect_kind)
            RK_BR: begin
                w_target  = w_rel_target;
                w_is_ctrl = i_br_taken;
            end
            RK_JAL: begin
                w_target  = w_rel_target;
                w_is_ctrl = 1'b1;
            end
            RK_JALR: begin
                w_target  = w_jalr_target;
                w_is_ctrl = 1'b1;
            end
            RK_TRAP: begin
                w_target = i_trap_vector & c_CLR_B10;
                w_is_sys = 1'b1;
            end
            RK_XRET: begin
                w_target = i_epc & c_XRET_MSK;
                w_is_sys = 1'b1;
            end
            default: begin
                w_target  = '0;
                w_is_ctrl = 1'b0;
                w_is_sys  = 1'b0;
            end
        endcase
    end

    assign w_misalign = i_redirect_valid && w_is_ctrl && !C_EXT && w_target[1];

    assign o_target   = w_target;
    assign o_misalign = w_misalign;
    assign o_take     = i_redirect_valid && (w_is_sys || (w_is_ctrl && !w_misalign));

endmodule : smol_pc_target
`default_nettype wire

// File: rtl/smol_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : smol_pc_unit
//  Purpose  : Architectural fetch PC with sequential step and redirects.
//  Revision : 1.0 - initial release
// ============================================================================
module smol_pc_unit
    import smol_pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter bit              C_EXT        = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_halt,
    input  logic                i_fetch_ready,
    input  logic                i_seq_is_c,
    input  logic                i_redirect_valid,
    input  redirect_kind_t      i_redirect_kind,
    input  logic                i_br_taken,
    input  logic [XLEN-1:0]     i_redirect_pc,
    input  logic                i_redirect_is_c,
    input  logic [XLEN-1:0]     i_rs1,
    input  logic [XLEN-1:0]     i_imm,
    input  logic [XLEN-1:0]     i_trap_vector,
    input  logic [XLEN-1:0]     i_epc,
    output logic [XLEN-1:0]     o_fetch_pc,
    output logic                o_fetch_valid,
    output logic                o_fetch_flush,
    output logic [XLEN-1:0]     o_link_pc,
    output logic                o_misalign_valid,
    output logic [XLEN-1:0]     o_misalign_addr
);

    logic [XLEN-1:0] r_fetch_pc;
    logic            r_fetch_valid;
    logic            r_fetch_flush;
    logic            r_misalign_valid;
    logic [XLEN-1:0] r_misalign_addr;

    logic [XLEN-1:0] w_target;
    logic            w_take;
    logic            w_misalign;
    logic            w_fire;
    logic [XLEN-1:0] w_seq_step;
    logic [XLEN-1:0] w_link_step;

    smol_pc_target #(
        .XLEN  (XLEN),
        .C_EXT (C_EXT)
    ) u_target (
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_kind  (i_redirect_kind),
        .i_br_taken       (i_br_taken),
        .i_redirect_pc    (i_redirect_pc),
        .i_rs1            (i_rs1),
        .i_imm            (i_imm),
        .i_trap_vector    (i_trap_vector),
        .i_epc            (i_epc),
        .o_target         (w_target),
        .o_take           (w_take),
        .o_misalign       (w_misalign)
    );

    assign w_fire      = r_fetch_valid && i_fetch_ready;
    assign w_seq_step  = (C_EXT && i_seq_is_c)      ? XLEN'(STEP_16) : XLEN'(STEP_32);
    assign w_link_step = (C_EXT && i_redirect_is_c) ? XLEN'(STEP_16) : XLEN'(STEP_32);

    // A redirect takes precedence over a handshake in the same cycle, so the
    // sequential increment is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc       <= RESET_VECTOR;
            r_fetch_valid    <= 1'b0;
            r_fetch_flush    <= 1'b0;
            r_misalign_valid <= 1'b0;
            r_misalign_addr  <= '0;
        end else begin
            r_fetch_valid    <= !i_halt;
            r_fetch_flush    <= w_take;
            r_misalign_valid <= w_misalign;
            if (w_misalign) begin
                r_misalign_addr <= w_target;
            end
            if (w_take) begin
                r_fetch_pc <= w_target;
            end else if (w_fire) begin
                r_fetch_pc <= r_fetch_pc + w_seq_step;
            end
        end
    end

    assign o_fetch_pc       = r_fetch_pc;
    assign o_fetch_valid    = r_fetch_valid;
    assign o_fetch_flush    = r_fetch_flush;
    assign o_link_pc        = i_redirect_pc + w_link_step;
    assign o_misalign_valid = r_misalign_valid;
    assign o_misalign_addr  = r_misalign_addr;

endmodule : smol_pc_unit
`default_nettype wire

// File: tb/tb_smol_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_smol_pc_unit
//  Purpose  : Scoreboard bench running a C_EXT=0 and a C_EXT=1 unit in step.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_smol_pc_unit;
    import smol_pc_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           halt, fetch_ready, seq_is_c, redirect_valid, br_taken, redirect_is_c;
    redirect_kind_t redirect_kind;
    logic [31:0]    redirect_pc, rs1, imm, trap_vector, epc;

    logic [31:0]    pc0, pc1, link0, link1, ma0, ma1;
    logic           v0, v1, f0, f1, m0, m1;

    always #5 clk = ~clk;

    smol_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_halt(halt), .i_fetch_ready(fetch_ready),
        .i_seq_is_c(seq_is_c), .i_redirect_valid(redirect_valid),
        .i_redirect_kind(redirect_kind), .i_br_taken(br_taken),
        .i_redirect_pc(redirect_pc), .i_redirect_is_c(redirect_is_c),
        .i_rs1(rs1), .i_imm(imm), .i_trap_vector(trap_vector), .i_epc(epc),
        .o_fetch_pc(pc0), .o_fetch_valid(v0), .o_fetch_flush(f0),
        .o_link_pc(link0), .o_misalign_valid(m0), .o_misalign_addr(ma0)
    );

    smol_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_halt(halt), .i_fetch_ready(fetch_ready),
        .i_seq_is_c(seq_is_c), .i_redirect_valid(redirect_valid),
        .i_redirect_kind(redirect_kind), .i_br_taken(br_taken),
        .i_redirect_pc(redirect_pc), .i_redirect_is_c(redirect_is_c),
        .i_rs1(rs1), .i_imm(imm), .i_trap_vector(trap_vector), .i_epc(epc),
        .o_fetch_pc(pc1), .o_fetch_valid(v1), .o_fetch_flush(f1),
        .o_link_pc(link1), .o_misalign_valid(m1), .o_misalign_addr(ma1)
    );

    // Expected state vector: {valid, flush, misalign_valid, fetch_pc, misalign_addr}
    typedef struct {
        string       name;
        bit          sel;
        logic [66:0] exp;
    } sb_t;

    sb_t         sb[$];
    sb_t         e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ema0, ema1;

    function automatic logic [66:0] st(logic v, logic f, logic mv, logic [31:0] pc, logic [31:0] ma);
        return {v, f, mv, pc, ma};
    endfunction

    function automatic logic [66:0] obs(bit sel);
        return sel ? {v1, f1, m1, pc1, ma1} : {v0, f0, m0, pc0, ma0};
    endfunction

    task automatic push2(string n, logic [66:0] e0, logic [66:0] e1);
        sb.push_back('{name: n, sel: 1'b0, exp: e0});
        sb.push_back('{name: n, sel: 1'b1, exp: e1});
    endtask

    task automatic idle();
        redirect_valid = 1'b0; redirect_kind = RK_BR; br_taken = 1'b0;
        redirect_pc = '0; redirect_is_c = 1'b0; rs1 = '0; imm = '0;
        trap_vector = '0; epc = '0; seq_is_c = 1'b0;
    endtask

    task automatic redir(redirect_kind_t k, logic [31:0] rpc, logic [31:0] im);
        redirect_valid = 1'b1; redirect_kind = k; redirect_pc = rpc; imm = im;
    endtask

    task automatic test_reset();
        idle(); halt = 1'b0; fetch_ready = 1'b1; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push2("reset_state", st(0, 0, 0, 32'h0, 32'h0), st(0, 0, 0, 32'h0, 32'h0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.sel) !== e.exp) begin
                errors++;
                $display("FAIL %s dut%0d: got %h expected %h", e.name, e.sel, obs(e.sel), e.exp);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            push2("seq_after_reset", st(1, 0, 0, 32'(c * 4), 32'h0), st(1, 0, 0, 32'(c * 4), 32'h0));
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (obs(e.sel) !== e.exp) begin
                    errors++;
                    $display("FAIL %s dut%0d: got %h expected %h", e.name, e.sel, obs(e.sel), e.exp);
                end
            end
        end
    endtask

    task automatic test_stall();
        fetch_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            push2("stall_hold", st(1, 0, 0, 32'h8, 32'h0), st(1, 0, 0, 32'h8, 32'h0));
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (obs(e.sel) !== e.exp) begin
                    errors++;
                    $display("FAIL %s dut%0d: got %h expected %h", e.name, e.sel, obs(e.sel), e.exp);
                end
            end
        end
        fetch_ready = 1'b1;
    endtask

    task automatic test_jal();
        for (int c = 0; c < 2; c++) begin
            idle();
            if (c == 0) begin
                redir(RK_JAL, 32'h100, 32'h20);
                #1;
                checks++;
                if (link0 !== 32'h104 || link1 !== 32'h104) begin
                    errors++;
                    $display("FAIL jal_link: got %h/%h expected 00000104", link0, link1);
                end
                push2("jal_redirect", st(1, 1, 0, 32'h120, 32'h0), st(1, 1, 0, 32'h120, 32'h0));
            end else begin
                push2("jal_after", st(1, 0, 0, 32'h124, 32'h0), st(1, 0, 0, 32'h124, 32'h0));
            end
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (obs(e.sel) !== e.exp) begin
                    errors++;
                    $display("FAIL %s dut%0d: got %h expected %h", e.name, e.sel, obs(e.sel), e.exp);
                end
            end
        end
    endtask

    task automatic test_misalign();
        for (int c = 0; c < 2; c++) begin
            idle();
            if (c == 0) begin
                redir(RK_JALR, 32'h0, 32'h2); rs1 = 32'h1001;
                push2("jalr_misalign", st(1, 0, 1, 32'h128, 32'h1002), st(1, 1, 0, 32'h1002, 32'h0));
            end else begin
                push2("jalr_after", st(1, 0, 0, 32'h12C, 32'h1002), st(1, 0, 0, 32'h1006, 32'h0));
            end
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (obs(e.sel) !== e.exp) begin
                    errors++;
                    $display("FAIL %s dut%0d: got %h expected %h", e.name, e.sel, obs(e.sel), e.exp);
                end
            end
        end
    endtask

    task automatic test_branch();
        for (int c = 0; c < 3; c++) begin
            idle();
            case (c)
                0: begin
                    fetch_ready = 1'b0; redir(RK_BR, 32'h200, 32'h40); br_taken = 1'b0;
                    push2("br_not_taken", st(1, 0, 0, 32'h12C, 32'h1002), st(1, 0, 0, 32'h1006, 32'h0));
                end
                1: begin
                    fetch_ready = 1'b1; redir(RK_BR, 32'h200, 32'h40); br_taken = 1'b1;
                    push2("br_taken", st(1, 1, 0, 32'h240, 32'h1002), st(1, 1, 0, 32'h240, 32'h0));
                end
                default: begin
                    redir(RK_BR, 32'h200, 32'h42); br_taken = 1'b1;
                    push2("br_misalign", st(1, 0, 1, 32'h244, 32'h242), st(1, 1, 0, 32'h242, 32'h0));
                end
            endcase
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (obs(e.sel) !== e.exp) begin
                    errors++;
                    $display("FAIL %s dut%0d: got %h expected %h", e.name, e.sel, obs(e.sel), e.exp);
                end
            end
        end
    endtask

    task automatic test_trap_xret();
        ema0 = 32'h242; ema1 = 32'h0;
        for (int c = 0; c < 5; c++) begin
            idle();
            case (c)
                0: begin
                    fetch_ready = 1'b1; redir(RK_TRAP, 32'h0, 32'h0); trap_vector = 32'h8000_0003;
                    push2("trap", st(1, 1, 0, 32'h8000_0000, ema0), st(1, 1, 0, 32'h8000_0000, ema1));
                end
                1: begin
                    redir(RK_XRET, 32'h0, 32'h0); epc = 32'h42;
                    push2("xret_b2b", st(1, 1, 0, 32'h40, ema0), st(1, 1, 0, 32'h42, ema1));
                end
                2: push2("xret_after", st(1, 0, 0, 32'h44, ema0), st(1, 0, 0, 32'h46, ema1));
                3: begin
                    fetch_ready = 1'b0; redir(RK_TRAP, 32'h0, 32'h0); trap_vector = 32'h44;
                    push2("trap_same", st(1, 1, 0, 32'h44, ema0), st(1, 1, 0, 32'h44, ema1));
                end
                default: push2("trap_settle", st(1, 0, 0, 32'h44, ema0), st(1, 0, 0, 32'h44, ema1));
            endcase
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (obs(e.sel) !== e.exp) begin
                    errors++;
                    $display("FAIL %s dut%0d: got %h expected %h", e.name, e.sel, obs(e.sel), e.exp);
                end
            end
        end
    endtask

    task automatic test_halt();
        fetch_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            idle();
            halt = (c < 3);
            case (c)
                // valid is still high on the first halted edge, so that fetch fires
                0: push2("halt_enter", st(0, 0, 0, 32'h48, ema0), st(0, 0, 0, 32'h48, ema1));
                1: push2("halt_hold", st(0, 0, 0, 32'h48, ema0), st(0, 0, 0, 32'h48, ema1));
                2: begin
                    redir(RK_JAL, 32'h300, 32'h10);
                    push2("halt_redirect", st(0, 1, 0, 32'h310, ema0), st(0, 1, 0, 32'h310, ema1));
                end
                3: push2("halt_exit", st(1, 0, 0, 32'h310, ema0), st(1, 0, 0, 32'h310, ema1));
                default: push2("halt_resume", st(1, 0, 0, 32'h314, ema0), st(1, 0, 0, 32'h314, ema1));
            endcase
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (obs(e.sel) !== e.exp) begin
                    errors++;
                    $display("FAIL %s dut%0d: got %h expected %h", e.name, e.sel, obs(e.sel), e.exp);
                end
            end
        end
        halt = 1'b0;
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 2; c++) begin
            idle();
            if (c == 0) begin
                redir(RK_JAL, 32'hFFFF_FF00, 32'hFC);
                push2("wrap_setup", st(1, 1, 0, 32'hFFFF_FFFC, ema0), st(1, 1, 0, 32'hFFFF_FFFC, ema1));
            end else begin
                push2("wrap_step", st(1, 0, 0, 32'h0, ema0), st(1, 0, 0, 32'h0, ema1));
            end
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (obs(e.sel) !== e.exp) begin
                    errors++;
                    $display("FAIL %s dut%0d: got %h expected %h", e.name, e.sel, obs(e.sel), e.exp);
                end
            end
        end
    endtask

    task automatic test_compressed();
        for (int c = 0; c < 3; c++) begin
            idle();
            if (c == 0) begin
                redir(RK_JAL, 32'h10, 32'h0); redirect_is_c = 1'b1;
                #1;
                checks++;
                if (link0 !== 32'h14 || link1 !== 32'h12) begin
                    errors++;
                    $display("FAIL link_c: got %h/%h expected 00000014/00000012", link0, link1);
                end
                push2("c_setup", st(1, 1, 0, 32'h10, ema0), st(1, 1, 0, 32'h10, ema1));
            end else begin
                seq_is_c = 1'b1;
                push2("c_step", st(1, 0, 0, 32'h10 + 32'(c * 4), ema0), st(1, 0, 0, 32'h10 + 32'(c * 2), ema1));
            end
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (obs(e.sel) !== e.exp) begin
                    errors++;
                    $display("FAIL %s dut%0d: got %h expected %h", e.name, e.sel, obs(e.sel), e.exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        idle(); fetch_ready = 1'b1;
        redir(RK_TRAP, 32'h0, 32'h0); trap_vector = 32'h500;
        #2;
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) begin
                push2("reset_async", st(0, 0, 0, 32'h0, 32'h0), st(0, 0, 0, 32'h0, 32'h0));
            end else if (c == 1) begin
                @(posedge clk); #1;
                push2("reset_hold", st(0, 0, 0, 32'h0, 32'h0), st(0, 0, 0, 32'h0, 32'h0));
            end else begin
                idle(); rst_n = 1'b1;
                @(posedge clk); #1;
                push2("reset_release", st(1, 0, 0, 32'h0, 32'h0), st(1, 0, 0, 32'h0, 32'h0));
            end
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (obs(e.sel) !== e.exp) begin
                    errors++;
                    $display("FAIL %s dut%0d: got %h expected %h", e.name, e.sel, obs(e.sel), e.exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_jal();
        test_misalign();
        test_branch();
        test_trap_xret();
        test_halt();
        test_wrap();
        test_compressed();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_smol_pc_unit
`default_nettype wire

// File: doc/smol_pc_unit.md
Name: smol_pc_unit

Overview:
Parametrised successor to the core's next-PC logic. It owns the architectural fetch PC register, presents it to fetch over a valid/ready handshake, and advances it sequentially by 4, or by 2 when compressed support is enabled. It applies redirects from execute and commit (branch, JAL, JALR, trap, xRET) with a defined priority, flush and misalignment reporting. It sits between the execute/commit stages and the instruction-fetch front end.

Parameters:
XLEN, 32, datapath/address width
RESET_VECTOR, 32'h0000_0000, fetch_pc value after reset (XLEN bits)
C_EXT, 0, 1 = 2-byte instruction alignment and 2-byte sequential step allowed

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous, active-low reset
halt  in  1  suppress fetch_valid; PC held
fetch_ready  in  1  fetch accepts fetch_pc this cycle
seq_is_c  in  1  accepted instruction is compressed (ignored when C_EXT=0)
redirect_valid  in  1  redirect request this cycle
redirect_kind  in  3  redirect_kind_t: BR, JAL, JALR, TRAP, XRET
br_taken  in  1  branch resolved taken (used for BR only)
redirect_pc  in  XLEN  PC of the redirecting instruction
redirect_is_c  in  1  redirecting instruction is compressed
rs1  in  XLEN  JALR base
imm  in  XLEN  sign-extended immediate
trap_vector  in  XLEN  trap entry address
epc  in  XLEN  xRET return address
fetch_pc  out  XLEN  registered fetch address
fetch_valid  out  1  fetch_pc is a valid request
fetch_flush  out  1  one-cycle pulse: discard in-flight fetches
link_pc  out  XLEN  combinational redirect_pc + 4 (or + 2 if C_EXT and redirect_is_c)
misalign_valid  out  1  one-cycle pulse: rejected misaligned control transfer
misalign_addr  out  XLEN  offending target, held until next misalign

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_VECTOR, fetch_valid=0, fetch_flush=0, misalign_valid=0, misalign_addr=0.
- First clock after release: fetch_valid=1 unless halt.
- fetch_valid = !halt && out_of_reset, registered.
- Handshake fires on fetch_valid && fetch_ready. fetch_pc holds stable until fire or redirect.
- Sequential step on fire: fetch_pc += 2 if C_EXT && seq_is_c, else += 4. Wraps modulo 2^XLEN.
- Target computation, combinational:
  - BR: redirect_pc+imm, only when br_taken. Not-taken BR is ignored entirely.
  - JAL: redirect_pc+imm.
  - JALR: (rs1+imm) with bit 0 cleared.
  - TRAP: trap_vector with bits [1:0] cleared.
  - XRET: epc with bit 0 cleared (C_EXT=1) or bits [1:0] cleared (C_EXT=0).
- Misalignment applies to BR/JAL/JALR only: target[1]=1 with C_EXT=0. No redirect occurs; next cycle misalign_valid=1 and misalign_addr=target. fetch_pc continues per handshake and no flush is issued.
- Accepted redirect in cycle N: at N+1 fetch_pc=target and fetch_flush=1 for exactly one cycle.
- Redirect and fire in the same cycle: redirect wins and the sequential step is discarded.
- Redirect while halt=1: fetch_pc updates and fetch_flush pulses; fetch_valid stays 0.
- TRAP and XRET always redirect, including same-value targets.
- Back-to-back redirects are each applied; the last cycle's target is in force.
- Reset mid-redirect: async clear wins and no pulse survives.

Decomposition:
- Package smol_pc_pkg:
  - redirect_kind_t enum, 3 bits: RK_BR=0, RK_JAL=1, RK_JALR=2, RK_TRAP=3, RK_XRET=4.
  - Step constants STEP_32=4 and STEP_16=2.
- Sub-module smol_pc_target: combinational target, take, and misalign computation. The top module keeps all registers.

Test Plan:
- Reset release, halt=0, fetch_ready=1, C_EXT=0 -> fetch_valid=1 one cycle after release; fetch_pc sequence 0x0, 0x4, 0x8.
- fetch_ready=0 for 3 cycles at fetch_pc=0x8 -> fetch_pc holds 0x8 and fetch_valid stays 1.
- JAL redirect_pc=0x100, imm=0x20, same cycle as fire -> next cycle fetch_pc=0x120, fetch_flush=1 for one cycle; link_pc=0x104.
- JALR rs1=0x1001, imm=0x2 with C_EXT=0 -> target 0x1002 misaligned; misalign_valid=1, misalign_addr=0x1002, no flush. With C_EXT=1, same stimulus -> fetch_pc=0x1002.
- BR br_taken=0 -> no change; TRAP trap_vector=0x8000_0003 -> fetch_pc=0x8000_0000 and flush; XRET epc=0x40 -> fetch_pc=0x40.
- fetch_pc=0xFFFF_FFFC with fire -> fetch_pc=0x0. C_EXT=1 with seq_is_c=1 at 0x10 -> 0x12. rst_n asserted mid-run -> all outputs return to reset values immediately.
